led_status_decoder: RTL and testbench



---
 rtl/led_status_decoder.sv | 161 ++++++++++++++++
 tb/tb_led_status_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_status_decoder.sv
// led_status_decoder
//   Recovers the 2-bit status code carried on a remote board's blinking
//   status LED. Each frame is a long low gap followed by 1..3 slot-wide high
//   pulses separated by slot-wide lows, which give codes 0..2. A line held
//   high for a long time means code 3.
//
// Ports
//   Clk        in   system clock
//   Rst        in   synchronous active-high reset
//   led_in     in   blink line, asynchronous to Clk
//   state      out  last decoded status code
//   valid      out  high once any frame has been decoded since reset
//   frame_stb  out  one-cycle pulse each time state is (re)committed
//   err_stb    out  one-cycle pulse on a malformed frame
module led_status_decoder #(
    parameter int SLOT_CLKS   = 4,
    parameter int TOL_CLKS    = 1,
    parameter int GAP_SLOTS   = 8,
    parameter int SOLID_SLOTS = 16,
    parameter int CNT_W       = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       led_in,
    output logic [1:0] state,
    output logic       valid,
    output logic       frame_stb,
    output logic       err_stb
);

    localparam logic [CNT_W-1:0] GAP     = CNT_W'(GAP_SLOTS * SLOT_CLKS);
    localparam logic [CNT_W-1:0] SOLID   = CNT_W'(SOLID_SLOTS * SLOT_CLKS);
    localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(SLOT_CLKS - TOL_CLKS);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(SLOT_CLKS + TOL_CLKS);
    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    typedef enum logic [2:0] {
        SYNC, ARMED, PULSE_HI, PULSE_LO, SOLIDHI
    } fsm_t;

    fsm_t       fsm, fsm_nxt;
    logic       sync_q, s, s_prev;
    logic [CNT_W-1:0] run;
    logic [2:0] npulse, npulse_nxt;
    logic       commit, err;
    logic [1:0] code;
    logic       edge_det, rise, fall, legal, at_gap, at_solid;

    // While no edge is seen, run holds the width so far of the current
    // level; on an edge it still holds the width of the level that ended.
    assign edge_det = s ^ s_prev;
    assign rise     = edge_det & s;
    assign fall     = edge_det & ~s;
    assign legal    = (run >= LEN_MIN) && (run <= LEN_MAX);
    // An edge in the same cycle always wins over a run threshold.
    assign at_gap   = ~edge_det & ~s & (run == GAP);
    assign at_solid = ~edge_det &  s & (run == SOLID);

    // Input path: 2-flop synchroniser, edge detect and saturating run count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
            run    <= '0;
        end else begin
            sync_q <= led_in;
            s      <= sync_q;
            s_prev <= s;
            if (edge_det)
                run <= CNT_W'(1);
            else if (run != RUN_MAX)
                run <= run + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm    <= SYNC;
            npulse <= '0;
        end else begin
            fsm    <= fsm_nxt;
            npulse <= npulse_nxt;
        end
    end

    always_comb begin
        fsm_nxt    = fsm;
        npulse_nxt = npulse;
        commit     = 1'b0;
        err        = 1'b0;
        code       = state;
        case (fsm)
            SYNC: begin
                if (at_gap) begin
                    fsm_nxt = ARMED;
                end else if (at_solid) begin
                    commit  = 1'b1;
                    code    = 2'd3;
                    fsm_nxt = SOLIDHI;
                end
            end
            ARMED: begin
                npulse_nxt = '0;
                if (rise)
                    fsm_nxt = PULSE_HI;
            end
            PULSE_HI: begin
                if (fall) begin
                    if (!legal || npulse == 3'd3) begin
                        err = 1'b1;
                    end else begin
                        npulse_nxt = npulse + 3'd1;
                        fsm_nxt    = PULSE_LO;
                    end
                end else if (at_solid) begin
                    commit  = 1'b1;
                    code    = 2'd3;
                    fsm_nxt = SOLIDHI;
                end
            end
            PULSE_LO: begin
                if (rise) begin
                    if (legal)
                        fsm_nxt = PULSE_HI;
                    else
                        err = 1'b1;
                end else if (at_gap) begin
                    // npulse is 1..3 here, mapping to codes 0..2
                    commit  = 1'b1;
                    code    = 2'(npulse - 3'd1);
                    fsm_nxt = ARMED;
                end
            end
            SOLIDHI: begin
                if (fall)
                    fsm_nxt = SYNC;
            end
            default: fsm_nxt = SYNC;
        endcase
        if (err)
            fsm_nxt = SYNC;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= 2'd0;
            valid     <= 1'b0;
            frame_stb <= 1'b0;
            err_stb   <= 1'b0;
        end else begin
            frame_stb <= commit;
            err_stb   <= err;
            if (commit) begin
                state <= code;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_status_decoder.sv
// Directed bench for led_status_decoder: drives encoder-style frames and
// malformed frames, counts strobes on the falling clock edge, and compares
// the outputs with hand-computed values.
module tb_led_status_decoder;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       led_in = 1'b0;
    logic [1:0] state;
    logic       valid, frame_stb, err_stb;

    int cyc = 0;
    int nframe = 0;
    int nerr = 0;
    int t_stb = 0;
    int t_mark = 0;
    int checks = 0;
    int errors = 0;
    int f0, e0;

    led_status_decoder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .led_in    (led_in),
        .state     (state),
        .valid     (valid),
        .frame_stb (frame_stb),
        .err_stb   (err_stb)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (frame_stb) begin
            nframe <= nframe + 1;
            t_stb  <= cyc;
        end
        if (err_stb)
            nerr <= nerr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold led_in at v for n cycles; returns on a falling clock edge.
    task automatic level(input logic v, input int n);
        led_in = v;
        repeat (n) @(negedge Clk);
    endtask

    // n pulses of hw clocks separated by lows of lw, then a low of gapn.
    // t_mark is the cycle the final falling edge is driven.
    task automatic send(input int n, input int hw, input int lw, input int gapn);
        for (int i = 0; i < n; i++) begin
            level(1'b1, hw);
            if (i < n - 1) level(1'b0, lw);
        end
        t_mark = cyc;
        level(1'b0, gapn);
    endtask

    initial begin
        @(negedge Clk);
        repeat (3) @(negedge Clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame_stb", 32'(frame_stb), 0);
        chk("rst_err_stb", 32'(err_stb), 0);
        Rst = 1'b0;

        // code 2, encoder-style; latency = 2 sync + edge detect + 32 gap
        // counted from when the low is visible after the synchroniser
        level(1'b0, 40);
        f0 = nframe;
        send(3, 4, 4, 40);
        chk("c2_frames", 32'(nframe - f0), 1);
        chk("c2_state", 32'(state), 2);
        chk("c2_valid", 32'(valid), 1);
        chk("c2_latency_ok", 32'((t_stb - t_mark) >= 33 && (t_stb - t_mark) <= 35), 1);
        send(3, 4, 4, 40);
        chk("c2_repeat_frames", 32'(nframe - f0), 2);
        chk("c2_repeat_state", 32'(state), 2);

        // codes 0 and 1 back to back
        f0 = nframe;
        send(1, 4, 4, 44);
        chk("c0_state", 32'(state), 0);
        chk("c0_frames", 32'(nframe - f0), 1);
        send(2, 4, 4, 60);
        chk("c1_state", 32'(state), 1);
        chk("c1_frames", 32'(nframe - f0), 2);
        chk("c01_no_err", 32'(nerr), 0);

        // solid high: one commit only, even past run saturation
        f0 = nframe;
        t_mark = cyc;
        level(1'b1, 100);
        chk("solid_frames", 32'(nframe - f0), 1);
        chk("solid_state", 32'(state), 3);
        chk("solid_latency_ok", 32'((t_stb - t_mark) >= 65 && (t_stb - t_mark) <= 67), 1);
        level(1'b1, 300);
        chk("solid_sat_frames", 32'(nframe - f0), 1);
        level(1'b0, 40);
        chk("solid_fall_state", 32'(state), 3);
        send(2, 4, 4, 40);
        chk("after_solid_state", 32'(state), 1);
        chk("after_solid_frames", 32'(nframe - f0), 2);

        // tolerance edges: 3 and 5 clk widths
        f0 = nframe;
        send(3, 5, 3, 40);
        chk("tol_c2_state", 32'(state), 2);
        send(2, 3, 5, 40);
        chk("tol_c1_state", 32'(state), 1);
        chk("tol_frames", 32'(nframe - f0), 2);
        chk("tol_no_err", 32'(nerr), 0);

        // malformed frames: each gives one err_stb, state holds
        f0 = nframe;
        e0 = nerr;
        send(1, 6, 4, 40);
        chk("err_wide_cnt", 32'(nerr - e0), 1);
        send(1, 2, 4, 40);
        chk("err_narrow_cnt", 32'(nerr - e0), 2);
        send(2, 4, 10, 40);
        chk("err_longlow_cnt", 32'(nerr - e0), 3);
        send(4, 4, 4, 40);
        chk("err_4pulse_cnt", 32'(nerr - e0), 4);
        chk("err_state_hold", 32'(state), 1);
        chk("err_no_frames", 32'(nframe - f0), 0);
        send(3, 4, 4, 40);
        chk("err_recover_state", 32'(state), 2);
        chk("err_recover_frames", 32'(nframe - f0), 1);

        // reset between pulse 1 and pulse 2 of a code-2 frame
        f0 = nframe;
        e0 = nerr;
        level(1'b1, 4);
        level(1'b0, 2);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_frame_stb", 32'(frame_stb), 0);
        chk("mid_rst_err_stb", 32'(err_stb), 0);
        level(1'b0, 2);
        send(2, 4, 4, 40);
        chk("mid_rst_no_frame", 32'(nframe - f0), 0);
        chk("mid_rst_no_err", 32'(nerr - e0), 0);
        chk("mid_rst_valid_low", 32'(valid), 0);
        send(3, 4, 4, 40);
        chk("post_rst_state", 32'(state), 2);
        chk("post_rst_valid", 32'(valid), 1);
        chk("post_rst_frames", 32'(nframe - f0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
